irq_ctrl: RTL
=============

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8: number of interrupt sources, legal range 1..16.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port sel  input  1  register access select.
REQ-005 SHALL have port we  input  1  write strobe, qualified by sel.
REQ-006 SHALL have port addr  input  4  byte register offset.
REQ-007 SHALL have port wdata  input  32  write data.
REQ-008 SHALL have port rdata  output  32  read data, combinational on addr.
REQ-009 SHALL have port src  input  NUM_SRC  interrupt sources (timer timeout_irq on src[0]); synchronous to clk.
REQ-010 SHALL have port irq  output  1  registered CPU interrupt request.
REQ-011 SHALL have port irq_id  output  4  registered index of the highest-priority active source.

Function
REQ-012 SHALL map registers: 0x0 PENDING (R, W1C), 0x4 ENABLE (RW), 0x8 TYPE (RW; bit=1 edge, 0 level), 0xC CLAIM (RO).
REQ-013 SHALL apply a write when sel && we at a clock edge; writes to CLAIM or unmapped offsets are ignored.
REQ-014 SHALL return 0 for unmapped offsets and for all bits at or above NUM_SRC in every register.
REQ-015 SHALL hold a per-source delay register src_d; edge detect = src & ~src_d, src_d updated every cycle.
REQ-016 Edge source i: PENDING[i] SHALL set on a detected rising edge and clear only by writing 1 to PENDING bit i.
REQ-017 Edge source, simultaneous set and W1C on the same edge: set SHALL win; PENDING[i] stays 1.
REQ-018 Level source i: PENDING[i] SHALL load src[i] every cycle; W1C writes to it SHALL have no effect.
REQ-019 TYPE bit changed level->edge: PENDING[i] SHALL keep its current value, then follow edge rules.
REQ-020 PENDING SHALL update regardless of ENABLE; ENABLE masks only irq/irq_id/CLAIM.
REQ-021 active = PENDING & ENABLE; priority: lowest index wins.
REQ-022 irq SHALL register |active; irq_id SHALL register the lowest active index, 0 when none.
REQ-023 Latency: src rise before edge k -> PENDING=1 after edge k -> irq=1 after edge k+1.
REQ-024 W1C of the last active bit at edge k SHALL drop irq after edge k+1.
REQ-025 CLAIM read SHALL return {irq, 27'b0, irq_id} (bit31 = irq, bits3:0 = irq_id); no read side effects.
REQ-026 ENABLE write SHALL take effect on irq one cycle after the write edge.

Reset
REQ-027 reset high SHALL immediately clear PENDING, ENABLE, TYPE, src_d, irq and irq_id to 0, independent of clk.
REQ-028 A source held high across reset deassertion SHALL be seen as a rising edge on the first clock (src_d = 0).
REQ-029 reset asserted mid-operation SHALL discard all pending state; no interrupt is retained.

Verification
REQ-030 Edge: TYPE=0x01, ENABLE=0x01, pulse src[0] one cycle -> PENDING=0x01, irq=1 and irq_id=0 one cycle later, held after src falls; W1C 0x01 -> irq=0 one cycle later.
REQ-031 Priority: ENABLE=0xFF, TYPE=0xFF, rise src[5] and src[2] same cycle -> irq_id=2; W1C 0x04 -> irq_id=5, irq stays 1; W1C 0x20 -> irq=0.
REQ-032 Level: TYPE=0, ENABLE=0x08, hold src[3]=1 -> irq=1, irq_id=3; W1C 0x08 -> PENDING[3] stays 1; drop src[3] -> PENDING=0, irq=0 after 2 edges.
REQ-033 Mask: ENABLE=0, TYPE=0x01, rise src[0] -> PENDING=0x01, irq=0; write ENABLE=0x01 -> irq=1 next cycle; CLAIM reads 0x80000000.
REQ-034 Collision: PENDING[1]=1 in edge mode; new rise on src[1] on the same edge as W1C 0x02 -> PENDING[1]=1.
REQ-035 Reset: assert reset mid-pending with irq=1 -> all registers, irq and irq_id read 0 without a clock edge.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller with per-source edge/level
// selection, enable masking and a fixed lowest-index-wins priority encoder.
module irq_ctrl #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sel,
  input  logic               we,
  input  logic [3:0]         addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  input  logic [NUM_SRC-1:0] src,
  output logic               irq,
  output logic [3:0]         irq_id
);

  localparam logic [3:0] OFF_PENDING = 4'h0;
  localparam logic [3:0] OFF_ENABLE  = 4'h4;
  localparam logic [3:0] OFF_TYPE    = 4'h8;
  localparam logic [3:0] OFF_CLAIM   = 4'hC;
  localparam int         PAD         = 32 - NUM_SRC;

  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] src_type;
  logic [NUM_SRC-1:0] src_d;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] pending_nxt;
  logic               wr;
  logic               any_active;
  logic [3:0]         first_id;
  logic               unused_wdata;

  assign wr           = sel & we;
  assign unused_wdata = ^wdata;

  // Edge detection, W1C mask and per-source next PENDING value
  always_comb begin
    rise   = src & ~src_d;
    w1c    = (wr && addr == OFF_PENDING) ? wdata[NUM_SRC-1:0] : '0;
    active = pending & enable;
    pending_nxt = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      // edge mode: a new rise beats a same-cycle W1C; level mode ignores W1C
      pending_nxt[i] = src_type[i] ? (rise[i] | (pending[i] & ~w1c[i])) : src[i];
    end
  end

  // Priority encoder: scan downward so the lowest active index is kept last
  always_comb begin
    any_active = |active;
    first_id   = '0;
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (active[i-1]) first_id = 4'(i - 1);
    end
  end

  // Register read mux; bits above NUM_SRC and unmapped offsets read as zero
  always_comb begin
    rdata = '0;
    unique case (addr)
      OFF_PENDING: rdata = {{PAD{1'b0}}, pending};
      OFF_ENABLE:  rdata = {{PAD{1'b0}}, enable};
      OFF_TYPE:    rdata = {{PAD{1'b0}}, src_type};
      OFF_CLAIM:   rdata = {irq, 27'b0, irq_id};
      default:     rdata = '0;
    endcase
  end

  // Controller state: configuration, pending bits, source delay and outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= '0;
      enable   <= '0;
      src_type <= '0;
      src_d    <= '0;
      irq      <= 1'b0;
      irq_id   <= '0;
    end else begin
      pending <= pending_nxt;
      src_d   <= src;
      irq     <= any_active;
      irq_id  <= first_id;
      if (wr && addr == OFF_ENABLE) enable   <= wdata[NUM_SRC-1:0];
      if (wr && addr == OFF_TYPE)   src_type <= wdata[NUM_SRC-1:0];
    end
  end

endmodule
